board_top_reg_file32: RTL and testbench

BOARD_TOP_REG_FILE32 -- requirements
Module: board_top_reg_file32

---
 rtl/board_top_reg_file32_pkg.sv | 50 +++++
 rtl/reg_file32.sv | 38 +++
 rtl/reg_file32_top.sv | 123 ++++++++++++
 rtl/board_top_reg_file32.sv | 103 ++++++++++
 tb/tb_board_top_reg_file32.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/board_top_reg_file32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : board_top_reg_file32_pkg
// Description : Shared widths, ALU opcode encodings, flag bit positions and
//               the 7-segment hex decoder for the register-file board.
// Revision    : 1.0 - initial release
// ============================================================================
package board_top_reg_file32_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;
    localparam int FLAG_W   = 4;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;

    // Flag vector is {ZF,CF,OF,SF}, ZF in the MSB so it lands on led[1].
    localparam int FLAG_ZF = 3;
    localparam int FLAG_CF = 2;
    localparam int FLAG_OF = 1;
    localparam int FLAG_SF = 0;

    typedef enum logic [1:0] {
        DISP_F     = 2'b00,
        DISP_ALU_A = 2'b01,
        DISP_ALU_B = 2'b10,
        DISP_REG_A = 2'b11
    } disp_sel_e;

    // Active-low segments, bit order g..a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] on;
        case (v)
            4'h0: on = 7'h3F;  4'h1: on = 7'h06;  4'h2: on = 7'h5B;  4'h3: on = 7'h4F;
            4'h4: on = 7'h66;  4'h5: on = 7'h6D;  4'h6: on = 7'h7D;  4'h7: on = 7'h07;
            4'h8: on = 7'h7F;  4'h9: on = 7'h6F;  4'hA: on = 7'h77;  4'hB: on = 7'h7C;
            4'hC: on = 7'h39;  4'hD: on = 7'h5E;  4'hE: on = 7'h79;  default: on = 7'h71;
        endcase
        return ~on;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file32.sv
`default_nettype none
// ============================================================================
// Module      : reg_file32
// Description : 32 x 32-bit register file, two async read ports, one write.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file32
    import board_top_reg_file32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] reg_file [0:NUM_REGS-1];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                reg_file[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            reg_file[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = reg_file[i_raddr_a];
    assign o_rdata_b = reg_file[i_raddr_b];

endmodule
`default_nettype wire

// File: rtl/reg_file32_top.sv
`default_nettype none
// ============================================================================
// Module      : reg_file32_top
// Description : Register file with operand latches, ALU, result/flag latches.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file32_top
    import board_top_reg_file32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_pulse_rr,
    input  logic              i_pulse_f,
    input  logic              i_pulse_wb,
    input  logic              i_cus_enable,
    input  logic [3:0]        i_cus,
    input  logic              i_reg_write,
    input  logic [ADDR_W-1:0] i_w_addr,
    input  logic [ADDR_W-1:0] i_r_addr_a,
    input  logic [ADDR_W-1:0] i_r_addr_b,
    input  logic [3:0]        i_alu_op,
    output logic [DATA_W-1:0] o_f,
    output logic [FLAG_W-1:0] o_flags,
    output logic [DATA_W-1:0] o_alu_a,
    output logic [DATA_W-1:0] o_alu_b,
    output logic [DATA_W-1:0] o_reg_a
);

    logic [DATA_W-1:0] reg_a, reg_b, alu_a, alu_b, alu_f, F;
    logic [FLAG_W-1:0] F_;
    logic [DATA_W-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d, f_q, f_d;
    logic [FLAG_W-1:0] flags_q, flags_d, alu_flags;
    logic [DATA_W:0]   w_sum, w_diff;
    logic [DATA_W-1:0] w_wdata;

    assign w_wdata = i_cus_enable ? {{(DATA_W-4){1'b0}}, i_cus} : F;

    reg_file32 reg_file32_inst (
        .clk       (clk),
        .rst       (rst),
        .i_we      (i_pulse_wb & i_reg_write),
        .i_waddr   (i_w_addr),
        .i_wdata   (w_wdata),
        .i_raddr_a (i_r_addr_a),
        .i_raddr_b (i_r_addr_b),
        .o_rdata_a (reg_a),
        .o_rdata_b (reg_b)
    );

    assign alu_a = alu_a_q;
    assign alu_b = alu_b_q;
    assign F     = f_q;
    assign F_    = flags_q;

    // Bit DATA_W of the sum is carry-out; of the difference, the borrow.
    assign w_sum  = {1'b0, alu_a} + {1'b0, alu_b};
    assign w_diff = {1'b0, alu_a} - {1'b0, alu_b};

    always_comb begin
        alu_f     = '0;
        alu_flags = '0;
        case (i_alu_op)
            ALU_ADD: begin
                alu_f              = w_sum[DATA_W-1:0];
                alu_flags[FLAG_CF] = w_sum[DATA_W];
                alu_flags[FLAG_OF] = (alu_a[DATA_W-1] == alu_b[DATA_W-1]) &&
                                     (w_sum[DATA_W-1] != alu_a[DATA_W-1]);
            end
            ALU_SUB: begin
                alu_f              = w_diff[DATA_W-1:0];
                alu_flags[FLAG_CF] = w_diff[DATA_W];
                alu_flags[FLAG_OF] = (alu_a[DATA_W-1] != alu_b[DATA_W-1]) &&
                                     (w_diff[DATA_W-1] != alu_a[DATA_W-1]);
            end
            ALU_AND:  alu_f = alu_a & alu_b;
            ALU_OR:   alu_f = alu_a | alu_b;
            ALU_XOR:  alu_f = alu_a ^ alu_b;
            ALU_NOR:  alu_f = ~(alu_a | alu_b);
            ALU_SLTU: alu_f = {{(DATA_W-1){1'b0}}, (alu_a < alu_b)};
            ALU_SLL:  alu_f = alu_b << alu_a[ADDR_W-1:0];
            default:  alu_f = '0;
        endcase
        alu_flags[FLAG_ZF] = (alu_f == '0);
        alu_flags[FLAG_SF] = alu_f[DATA_W-1];
    end

    always_comb begin
        alu_a_d = alu_a_q;
        alu_b_d = alu_b_q;
        f_d     = f_q;
        flags_d = flags_q;
        if (i_pulse_rr) begin
            alu_a_d = reg_a;
            alu_b_d = reg_b;
        end
        if (i_pulse_f) begin
            f_d     = alu_f;
            flags_d = alu_flags;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            f_q     <= '0;
            flags_q <= '0;
        end else begin
            alu_a_q <= alu_a_d;
            alu_b_q <= alu_b_d;
            f_q     <= f_d;
            flags_q <= flags_d;
        end
    end

    assign o_f     = F;
    assign o_flags = F_;
    assign o_alu_a = alu_a;
    assign o_alu_b = alu_b;
    assign o_reg_a = reg_a;

endmodule
`default_nettype wire

// File: rtl/board_top_reg_file32.sv
`default_nettype none
// ============================================================================
// Module      : board_top_reg_file32
// Description : Board wrapper: button synchronisers, datapath, 8-digit scan.
// Revision    : 1.0 - initial release
// ============================================================================
module board_top_reg_file32
    import board_top_reg_file32_pkg::*;
#(
    parameter int SCAN_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:4]  swb,
    input  logic [1:32] sw,
    output logic [1:4]  led,
    output logic [7:0]  seg,
    output logic [2:0]  which,
    output logic        enable
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    // Button vector order: [2]=clk_RR, [1]=clk_F, [0]=clk_WB.
    logic [2:0]        w_btn, sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic              w_pulse_rr, w_pulse_f, w_pulse_wb;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [2:0]        which_q, which_d;
    logic [DATA_W-1:0] w_f, w_alu_a, w_alu_b, w_reg_a, w_disp_val;
    logic [FLAG_W-1:0] w_flags;
    logic [3:0]        w_nibble;
    logic              w_unused_sw;

    assign w_btn       = {swb[1], swb[2], swb[3]};
    assign w_unused_sw = ^sw[22:27];

    always_comb begin
        sync1_d = w_btn;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
        div_d   = div_q + 1'b1;
        which_d = which_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d   = '0;
            which_d = which_q + 3'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            div_q   <= '0;
            which_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            div_q   <= div_d;
            which_q <= which_d;
        end
    end

    assign {w_pulse_rr, w_pulse_f, w_pulse_wb} = sync2_q & ~prev_q;

    reg_file32_top reg_file32_top_inst (
        .clk          (clk),
        .rst          (rst),
        .i_pulse_rr   (w_pulse_rr),
        .i_pulse_f    (w_pulse_f),
        .i_pulse_wb   (w_pulse_wb),
        .i_cus_enable (swb[4]),
        .i_cus        (sw[16:19]),
        .i_reg_write  (sw[28]),
        .i_w_addr     (sw[1:5]),
        .i_r_addr_a   (sw[6:10]),
        .i_r_addr_b   (sw[11:15]),
        .i_alu_op     (sw[29:32]),
        .o_f          (w_f),
        .o_flags      (w_flags),
        .o_alu_a      (w_alu_a),
        .o_alu_b      (w_alu_b),
        .o_reg_a      (w_reg_a)
    );

    always_comb begin
        case (disp_sel_e'(sw[20:21]))
            DISP_F:     w_disp_val = w_f;
            DISP_ALU_A: w_disp_val = w_alu_a;
            DISP_ALU_B: w_disp_val = w_alu_b;
            default:    w_disp_val = w_reg_a;
        endcase
    end

    assign w_nibble = w_disp_val[{which_q, 2'b00} +: 4];
    assign led      = w_flags;
    assign which    = which_q;
    assign enable   = ~rst;
    assign seg      = rst ? 8'hFF : {1'b1, hex_to_seg(w_nibble)};

endmodule
`default_nettype wire

// File: tb/tb_board_top_reg_file32.sv
`default_nettype none
// ============================================================================
// Module      : tb_board_top_reg_file32
// Description : Directed self-checking bench for board_top_reg_file32.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_board_top_reg_file32;

    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:4]  swb;
    logic [1:32] sw;
    logic [1:4]  led;
    logic [7:0]  seg;
    logic [2:0]  which;
    logic        enable;

    logic       b_rr = 0, b_f = 0, b_wb = 0, cus_en = 0, rw = 0;
    logic [4:0] waddr = 0, ra = 0, rb = 0;
    logic [3:0] cus = 0, op = 0;
    logic [1:0] dsel = 0;

    int checks = 0;
    int errors = 0;
    int pulses;

    assign swb = {b_rr, b_f, b_wb, cus_en};
    assign sw  = {waddr, ra, rb, cus, dsel, 6'b0, rw, op};

    always #5 clk = ~clk;

    board_top_reg_file32 #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .swb    (swb),
        .sw     (sw),
        .led    (led),
        .seg    (seg),
        .which  (which),
        .enable (enable)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // btn: 0=RR, 1=F, 2=WB
    task automatic press(input int btn);
        @(negedge clk);
        case (btn)
            0: b_rr = 1'b1;
            1: b_f  = 1'b1;
            default: b_wb = 1'b1;
        endcase
        repeat (5) @(negedge clk);
        b_rr = 1'b0; b_f = 1'b0; b_wb = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_which(input logic [2:0] target);
        int n;
        n = 0;
        while (which !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) check("which_timeout", {29'b0, which}, {29'b0, target});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_led",    {28'b0, led},    32'h0);
        check("rst_which",  {29'b0, which},  32'h0);
        check("rst_enable", {31'b0, enable}, 32'h0);
        check("rst_seg",    {24'b0, seg},    32'hFF);
        rst = 1'b0;
        @(negedge clk);
        check("enable_on", {31'b0, enable}, 32'h1);

        cus = 4'hA; cus_en = 1; rw = 1; waddr = 5'd1;
        press(2);
        check("rf1_cus", dut.reg_file32_top_inst.reg_file32_inst.reg_file[1], 32'h0000000A);
        check("rf2_zero", dut.reg_file32_top_inst.reg_file32_inst.reg_file[2], 32'h0);

        waddr = 5'd2; press(2);
        ra = 5'd1; rb = 5'd2; press(0);
        op = 4'b0000; press(1);
        check("add_alu_a", dut.reg_file32_top_inst.alu_a, 32'hA);
        check("add_alu_b", dut.reg_file32_top_inst.alu_b, 32'hA);
        check("add_F",     dut.reg_file32_top_inst.F,     32'h14);
        check("add_led",   {28'b0, led}, 32'h0);

        cus_en = 0; waddr = 5'd3; press(2);
        check("rf3_F", dut.reg_file32_top_inst.reg_file32_inst.reg_file[3], 32'h14);
        rw = 0; waddr = 5'd4; press(2);
        check("rf4_nowrite", dut.reg_file32_top_inst.reg_file32_inst.reg_file[4], 32'h0);

        op = 4'b0001; press(1);
        check("sub_zero_F",   dut.reg_file32_top_inst.F, 32'h0);
        check("sub_zero_led", {28'b0, led}, 32'h8);

        cus = 4'h1; cus_en = 1; rw = 1; waddr = 5'd5; press(2);
        ra = 5'd0; rb = 5'd5; press(0);
        press(1);
        check("sub_neg_F",   dut.reg_file32_top_inst.F, 32'hFFFFFFFF);
        check("sub_neg_led", {28'b0, led}, 32'h5);

        cus_en = 0; waddr = 5'd6; press(2);
        check("rf6_F", dut.reg_file32_top_inst.reg_file32_inst.reg_file[6], 32'hFFFFFFFF);
        ra = 5'd6; rb = 5'd5; press(0);
        op = 4'b0111; press(1);
        check("sll_F",   dut.reg_file32_top_inst.F, 32'h80000000);
        check("sll_led", {28'b0, led}, 32'h1);
        waddr = 5'd7; press(2);
        ra = 5'd6; rb = 5'd7; press(0);
        op = 4'b0100; press(1);
        check("xor_F", dut.reg_file32_top_inst.F, 32'h7FFFFFFF);
        waddr = 5'd8; press(2);
        ra = 5'd8; rb = 5'd8; press(0);
        op = 4'b0000; press(1);
        check("ovf_F",   dut.reg_file32_top_inst.F, 32'hFFFFFFFE);
        check("ovf_led", {28'b0, led}, 32'h3);

        dsel = 2'b00;
        wait_which(3'd0);
        check("seg_digit0", {24'b0, seg}, 32'h86);
        wait_which(3'd1);
        check("seg_digit1", {24'b0, seg}, 32'h8E);

        waddr = 5'd0; press(2);
        ra = 5'd0;
        @(negedge clk);
        check("reg0_read", dut.reg_file32_top_inst.reg_a, 32'h0);

        // Long hold on RR: count pulses over the whole press.
        ra = 5'd3; rb = 5'd1; pulses = 0;
        @(negedge clk);
        b_rr = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (dut.w_pulse_rr) pulses++;
        end
        b_rr = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (dut.w_pulse_rr) pulses++;
        end
        check("hold_one_pulse", pulses, 32'd1);
        check("hold_alu_a", dut.reg_file32_top_inst.alu_a, 32'h14);

        // Reset in the middle of a pending WB press.
        cus = 4'h5; cus_en = 1; rw = 1; waddr = 5'd9;
        @(negedge clk);
        b_wb = 1'b1;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rf1",    dut.reg_file32_top_inst.reg_file32_inst.reg_file[1], 32'h0);
        check("mid_rst_alu_a",  dut.reg_file32_top_inst.alu_a, 32'h0);
        check("mid_rst_F",      dut.reg_file32_top_inst.F, 32'h0);
        check("mid_rst_led",    {28'b0, led}, 32'h0);
        check("mid_rst_which",  {29'b0, which}, 32'h0);
        check("mid_rst_enable", {31'b0, enable}, 32'h0);
        check("mid_rst_seg",    {24'b0, seg}, 32'hFF);
        b_wb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        repeat (2) @(negedge clk);
        check("scan_0", {29'b0, which}, 32'h0);
        for (int k = 1; k <= 9; k++) begin
            repeat (SCAN_DIV) @(negedge clk);
            check("scan_k", {29'b0, which}, k % 8);
        end
        check("rf9_aborted", dut.reg_file32_top_inst.reg_file32_inst.reg_file[9], 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
